// File: rtl/regb_fifo_pkg.sv
// Shared constants and helpers for the register-based shift FIFO (regb_fifo).
package regb_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regb_fifo_cell.sv
// One data+valid stage of the regb_fifo shift chain. Cell 0 is the head.
// A cell either takes its successor's contents (pop), loads si when it is
// the insertion point, or holds.
module regb_fifo_cell
    import regb_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] si,
    input  logic [WIDTH-1:0] nxt_data,
    input  logic             nxt_valid,
    input  logic             prv_valid,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Cell state update: shift toward the head, load at the tail, or hold.
    always_ff @(posedge clk) begin
        if (res) begin
            // NOTE: data is reset as well as valid, because out must read 0
            // after reset; without that requirement only valid would need it.
            data  <= '0;
            valid <= 1'b0;
        end else if (push && pop) begin
            // Occupancy is unchanged: inner cells shift, the tail cell refills.
            if (nxt_valid) begin
                // NOTE: non-blocking assignments let every cell sample its
                // neighbour's pre-edge value, which is what makes this a shift.
                data <= nxt_data;
            end else if (valid) begin
                data <= si;
            end
        end else if (pop) begin
            data  <= nxt_data;
            valid <= nxt_valid;
        end else if (push && !valid && prv_valid) begin
            data  <= si;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/regb_fifo.sv
// regb_fifo: multi-entry register FIFO built from DEPTH shift cells. The head
// cell drives out directly. Optional sticky error flags (ovf/udf/clr_err) are
// present only when REGB_FIFO_ERR_EN is defined.
module regb_fifo
    import regb_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] si,
    input  logic             shift_in,
    input  logic             shift_out,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full,
`ifdef REGB_FIFO_ERR_EN
    output logic             ovf,
    output logic             udf,
    input  logic             clr_err,
`endif
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data_arr  [DEPTH];
    logic             valid_arr [DEPTH];
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_nxt;

    // Flags come straight from cell valid bits, so there is no input-to-flag path.
    assign empty = ~valid_arr[0];
    assign full  = valid_arr[DEPTH-1];
    assign out   = data_arr[0];

    assign pop  = shift_out & valid_arr[0];
    assign push = shift_in & (~full | pop);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [WIDTH-1:0] nxt_d;
        logic             nxt_v;
        logic             prv_v;

        if (i == DEPTH - 1) begin : g_tail
            assign nxt_d = data_arr[i];
            assign nxt_v = 1'b0;
        end else begin : g_inner
            assign nxt_d = data_arr[i+1];
            assign nxt_v = valid_arr[i+1];
        end

        if (i == 0) begin : g_head
            assign prv_v = 1'b1;
        end else begin : g_body
            assign prv_v = valid_arr[i-1];
        end

        regb_fifo_cell #(.WIDTH(WIDTH)) u_cell (
            .clk       (clk),
            .res       (res),
            .si        (si),
            .nxt_data  (nxt_d),
            .nxt_valid (nxt_v),
            .prv_valid (prv_v),
            .push      (push),
            .pop       (pop),
            .data      (data_arr[i]),
            .valid     (valid_arr[i])
        );
    end

    // Next occupancy: up on push only, down on pop only.
    always_comb begin
        // NOTE: default first so every path assigns count_nxt and no latch is inferred.
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (res) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

`ifdef REGB_FIFO_ERR_EN
    logic ovf_set;
    logic udf_set;

    assign ovf_set = shift_in & full & ~shift_out;
    assign udf_set = shift_out & empty;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (res) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;
            if (udf_set)      udf <= 1'b1;
            else if (clr_err) udf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_regb_fifo.sv
// Self-checking bench for regb_fifo (WIDTH=8, DEPTH=4). A queue model holds
// the expected contents; popped values are compared against the queue head.
// Error-flag checks are compiled in when REGB_FIFO_ERR_EN is defined.
module tb_regb_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             res;
    logic [WIDTH-1:0] si;
    logic             shift_in;
    logic             shift_out;
    logic [WIDTH-1:0] out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
`ifdef REGB_FIFO_ERR_EN
    logic             ovf;
    logic             udf;
    logic             clr_err;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    regb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .res       (res),
        .si        (si),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .out       (out),
        .empty     (empty),
        .full      (full),
`ifdef REGB_FIFO_ERR_EN
        .ovf       (ovf),
        .udf       (udf),
        .clr_err   (clr_err),
`endif
        .count     (count)
    );

    // Drive one cycle; update the model; report the head seen before the edge
    // together with the value the model says is popped.
    task automatic do_cycle(input logic push_req, input logic pop_req,
                            input logic [WIDTH-1:0] d, output logic popped,
                            output logic [WIDTH-1:0] got,
                            output logic [WIDTH-1:0] exp);
        logic m_pop;
        logic m_push;
        shift_in  = push_req;
        shift_out = pop_req;
        si        = d;
        m_pop  = pop_req && (sb.size() != 0);
        m_push = push_req && ((sb.size() < DEPTH) || m_pop);
        popped = m_pop;
        got    = out;
        exp    = '0;
        if (m_pop)  exp = sb.pop_front();
        if (m_push) sb.push_back(d);
        @(posedge clk);
        #1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; shift_in = 1'b1; shift_out = 1'b0; si = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0; shift_in = 1'b0;
        sb.delete();
        n_total++; if (out !== 8'h00) $display("FAIL reset_out got=%h exp=00", out); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_total++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
`ifdef REGB_FIFO_ERR_EN
        n_total++; if ({ovf, udf} !== 2'b00) $display("FAIL reset_err got=%b%b exp=00", ovf, udf); else n_pass++;
`endif
    endtask

    task automatic test_fill_drain();
        logic p;
        logic [WIDTH-1:0] g, e;
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, WIDTH'(i), p, g, e);
            if (i == 1) begin
                n_total++; if (out !== 8'h01 || empty !== 1'b0) $display("FAIL first_push out=%h empty=%b exp 01/0", out, empty); else n_pass++;
            end
        end
        n_total++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else n_pass++;
        n_total++; if (count !== CW'(DEPTH)) $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, '0, p, g, e);
            n_total++; if (!p || g !== e) $display("FAIL drain_%0d got=%h exp=%h", i, g, e); else n_pass++;
            n_total++; if (count !== CW'(sb.size())) $display("FAIL drain_count_%0d got=%0d exp=%0d", i, count, sb.size()); else n_pass++;
        end
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_simul();
        logic p;
        logic [WIDTH-1:0] g, e;
        do_cycle(1'b1, 1'b0, 8'h11, p, g, e);
        do_cycle(1'b1, 1'b0, 8'h22, p, g, e);
        do_cycle(1'b1, 1'b1, 8'h33, p, g, e);
        n_total++; if (g !== e) $display("FAIL simul_pop got=%h exp=%h", g, e); else n_pass++;
        n_total++; if (out !== sb[0]) $display("FAIL simul_head got=%h exp=%h", out, sb[0]); else n_pass++;
        n_total++; if (count !== CW'(2)) $display("FAIL simul_count got=%0d exp=2", count); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b1, '0, p, g, e);
            n_total++; if (!p || g !== e) $display("FAIL simul_drain_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
        n_total++; if (empty !== 1'b1) $display("FAIL simul_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_full_boundary();
        logic p;
        logic [WIDTH-1:0] g, e;
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'hC0 + WIDTH'(i), p, g, e);
        do_cycle(1'b1, 1'b0, 8'hAA, p, g, e);
        n_total++; if (count !== CW'(DEPTH) || full !== 1'b1) $display("FAIL full_drop count=%0d full=%b exp %0d/1", count, full, DEPTH); else n_pass++;
`ifdef REGB_FIFO_ERR_EN
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf); else n_pass++;
`endif
        do_cycle(1'b1, 1'b1, 8'hBB, p, g, e);
        n_total++; if (!p || g !== e) $display("FAIL full_pushpop got=%h exp=%h", g, e); else n_pass++;
        n_total++; if (count !== CW'(DEPTH)) $display("FAIL full_pushpop_count got=%0d exp=%0d", count, DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, '0, p, g, e);
            n_total++; if (!p || g !== e) $display("FAIL full_drain_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
        n_total++; if (e !== 8'hBB) $display("FAIL full_last got=%h exp=bb", e); else n_pass++;
    endtask

    task automatic test_empty_boundary();
        logic p;
        logic [WIDTH-1:0] g, e;
        do_cycle(1'b0, 1'b1, '0, p, g, e);
        n_total++; if (count !== '0 || empty !== 1'b1) $display("FAIL empty_pop count=%0d empty=%b exp 0/1", count, empty); else n_pass++;
`ifdef REGB_FIFO_ERR_EN
        n_total++; if (udf !== 1'b1) $display("FAIL udf_set got=%b exp=1", udf); else n_pass++;
`endif
        do_cycle(1'b1, 1'b1, 8'h5A, p, g, e);
        n_total++; if (out !== 8'h5A || count !== CW'(1)) $display("FAIL empty_pushpop out=%h count=%0d exp 5a/1", out, count); else n_pass++;
`ifdef REGB_FIFO_ERR_EN
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        n_total++; if ({ovf, udf} !== 2'b00) $display("FAIL clr_err got=%b%b exp=00", ovf, udf); else n_pass++;
`endif
        do_cycle(1'b0, 1'b1, '0, p, g, e);
        n_total++; if (!p || g !== e) $display("FAIL empty_drain got=%h exp=%h", g, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic p;
        logic [WIDTH-1:0] g, e;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'h70 + WIDTH'(i), p, g, e);
        n_total++; if (count !== CW'(3)) $display("FAIL mid_fill got=%0d exp=3", count); else n_pass++;
        res = 1'b1; shift_in = 1'b1; shift_out = 1'b1; si = 8'h99;
        @(posedge clk);
        #1;
        res = 1'b0; shift_in = 1'b0; shift_out = 1'b0;
        sb.delete();
        n_total++; if (count !== '0 || empty !== 1'b1 || out !== 8'h00)
            $display("FAIL mid_reset count=%0d empty=%b out=%h exp 0/1/00", count, empty, out);
        else n_pass++;
    endtask

    initial begin
        res = 1'b1; si = '0; shift_in = 1'b0; shift_out = 1'b0;
`ifdef REGB_FIFO_ERR_EN
        clr_err = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_simul();
        test_full_boundary();
        test_empty_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regb_fifo.md
# regb_fifo

Parametrised register-based FIFO built from a chain of DEPTH shift cells. Data enters at the first free cell behind the occupied ones. On every pop the queue shifts one cell toward the head, so the head cell drives the output directly with no read mux. It is the multi-entry successor of the single-stage register FIFO unit, adding occupancy count, full/empty flags, simultaneous push/pop and optional error flags. It sits between producer and consumer logic in the same clock domain.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register cells (>= 2)
- CW, $clog2(DEPTH+1), width of the count output; derived, do not override
- clk  input  1  clock; all state updates on the rising edge
- res  input  1  reset; synchronous, active-high
- si  input  WIDTH  write data
- shift_in  input  1  push request
- shift_out  input  1  pop request
- out  output  WIDTH  head data; valid when empty = 0
- empty  output  1  no valid entries
- full  output  1  DEPTH valid entries
- count  output  CW  number of valid entries, 0..DEPTH
- ovf  output  1  sticky overflow flag; only with REGB_FIFO_ERR_EN
- udf  output  1  sticky underflow flag; only with REGB_FIFO_ERR_EN
- clr_err  input  1  clears ovf/udf; only with REGB_FIFO_ERR_EN

## Operation
- State per cell i (0 = head): data[i] (WIDTH) and valid[i]. valid[DEPTH] reads as 0. Valid cells are always contiguous from cell 0.
- Effective pop: pop = shift_out & valid[0].
- Effective push: push = shift_in & (~full | pop).
- Pop only, per cell: data[i] <= data[i+1]; valid[i] <= valid[i+1].
- Push only: the cell with valid[i] = 0 and (i = 0 or valid[i-1] = 1) loads si and sets valid.
- Push and pop together:
  - cells with valid[i+1] = 1 shift (data[i] <= data[i+1]);
  - the last valid cell (valid[i] = 1, valid[i+1] = 0) loads si;
  - count is unchanged.
- Push and pop when full: accepted; count stays DEPTH.
- Push when full without a pop: dropped; state unchanged.
- Pop when empty: ignored; with shift_in = 1 the push proceeds normally into cell 0.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- empty = ~valid[0]; full = valid[DEPTH-1]. Both are registered or derived from registers only, never from inputs.
- Data bits of invalid cells hold their last value. Only valid bits are functionally relevant, except that out must read 0 after reset.

## Timing
- Reset (res = 1 at an edge): all valid and data bits cleared. Resulting outputs: out = 0, empty = 1, full = 0, count = 0, ovf = udf = 0. Reset overrides any push or pop in the same cycle.
- Reset mid-operation discards all contents within one edge.
- Write-to-read latency is 1 cycle. A push into an empty FIFO at edge n gives out = si and empty = 0 after edge n.
- After a pop at edge n, out shows the next entry after edge n.
- No combinational path from shift_in or shift_out to out, empty, full or count.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.

## Configuration
- REGB_FIFO_ERR_EN defined:
  - ovf sets on shift_in & full & ~shift_out;
  - udf sets on shift_out & empty;
  - both stay set until res or clr_err;
  - if clr_err and a new error occur in the same cycle, the set wins.
- REGB_FIFO_ERR_EN undefined: ovf, udf and clr_err ports and their logic are absent. Illegal requests are silently ignored as described above.

## Structure
- Shared package regb_fifo_pkg holds:
  - default WIDTH and DEPTH constants;
  - the count-width function (clog2 of DEPTH+1).
- Sub-module regb_fifo_cell: one data+valid stage.
  - Inputs: clk, res, si, next-cell data and valid, previous-cell valid, push, pop.
  - Outputs: data and valid.
  - Instantiated DEPTH times in a generate loop. The top level holds count, flags and the error logic.

## Test plan
- Reset: assert res 2 cycles with shift_in = 1 -> out = 0, empty = 1, full = 0, count = 0.
- Fill and drain, DEPTH = 4: push 0x01, 0x02, 0x03, 0x04 -> full = 1, count = 4; pop 4 times -> out sequence 0x01..0x04, then empty = 1.
- Simultaneous push/pop: with 0x11 and 0x22 queued, push 0x33 and pop in one cycle -> out = 0x22, count = 2; next pops yield 0x22 then 0x33.
- Full boundary: at full, push 0xAA alone -> dropped, count = 4, ovf = 1 (ERR_EN). Push 0xBB with pop -> accepted, last entry popped = 0xBB.
- Empty boundary: pop while empty -> count stays 0, udf = 1 (ERR_EN). Push 0x5A and pop while empty -> out = 0x5A, count = 1. Pulse clr_err -> udf = 0.
- Reset mid-operation: with 3 entries, assert res together with push and pop -> next cycle count = 0, empty = 1, out = 0.
